// File: rtl/io_input_debounce_if.sv
// Board I/O input bundle: raw switch/key levels in,
// debounced status words out to the input ports.
interface io_input_debounce_if #(
  parameter int N_SW  = 10,
  parameter int N_KEY = 4
);
  logic [N_SW-1:0]  sw;
  logic [N_KEY-1:0] key_n;
  logic             ack_clr;
  logic [31:0]      in_port0;
  logic [31:0]      in_port1;

  modport master (
    output sw,
    output key_n,
    output ack_clr,
    input  in_port0,
    input  in_port1
  );

  modport slave (
    input  sw,
    input  key_n,
    input  ack_clr,
    output in_port0,
    output in_port1
  );
endinterface

// File: rtl/io_input_debounce.sv
// Switch/key synchronizer + debouncer with press flags
// and a key-0 press counter exposed as two 32-bit words.
module io_input_debounce #(
  parameter int N_SW      = 10,
  parameter int N_KEY     = 4,
  parameter int DB_CYCLES = 16
) (
  input logic            io_clk,
  input logic            reset,
  io_input_debounce_if.slave io
);
  localparam int NB = N_SW + N_KEY;
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic [N_SW-1:0]  sw_s1, sw_s2;
  logic [N_KEY-1:0] key_s1, key_s2;
  logic [NB-1:0]    lvl;
  logic [NB-1:0]    db, db_nxt;
  logic [CW-1:0]    cnt [NB];
  logic [CW-1:0]    cnt_nxt [NB];
  logic [N_KEY-1:0] key_rise;
  logic [N_KEY-1:0] press_flag;
  logic [7:0]       press_cnt;
  logic [31:0]      p0;
  logic [3:0]       key4, flag4;

  // keys inverted so level 1 means pressed
  assign lvl = {~key_s2, sw_s2};

  // two-flop synchronizers, keys reset to released
  always_ff @(posedge io_clk) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      sw_s1  <= io.sw;
      sw_s2  <= sw_s1;
      key_s1 <= io.key_n;
      key_s2 <= key_s1;
    end
  end

  // per-bit stability count; any return to db clears it
  always_comb begin
    db_nxt = db;
    for (int i = 0; i < NB; i++) begin
      cnt_nxt[i] = '0;
      if (lvl[i] != db[i]) begin
        if (cnt[i] == CMAX) begin
          db_nxt[i] = lvl[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign key_rise = db_nxt[NB-1:N_SW] & ~db[NB-1:N_SW];

  // debounced state, press flags and key-0 press count
  always_ff @(posedge io_clk) begin
    if (reset) begin
      db         <= '0;
      press_flag <= '0;
      press_cnt  <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      db <= db_nxt;
      for (int i = 0; i < NB; i++) cnt[i] <= cnt_nxt[i];
      if (io.ack_clr) press_flag <= key_rise;
      else            press_flag <= press_flag | key_rise;
      if (key_rise[0]) press_cnt <= press_cnt + 8'd1;
    end
  end

  // zero-pad register fields into the port words
  always_comb begin
    p0 = '0;
    p0[N_SW-1:0] = db[N_SW-1:0];
    key4 = '0;
    key4[N_KEY-1:0] = db[NB-1:N_SW];
    flag4 = '0;
    flag4[N_KEY-1:0] = press_flag;
  end

  assign io.in_port0 = p0;
  assign io.in_port1 = {16'b0, press_cnt, flag4, key4};
endmodule

// File: tb/tb_io_input_debounce.sv
// Self-checking bench: window-based reference model of
// the debouncer, directed scenarios plus random traffic.
module tb_io_input_debounce;
  localparam int N_SW  = 10;
  localparam int N_KEY = 4;
  localparam int DB    = 16;
  localparam int NB    = N_SW + N_KEY;

  logic io_clk = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  io_input_debounce_if #(.N_SW(N_SW), .N_KEY(N_KEY)) io();

  io_input_debounce #(
    .N_SW(N_SW), .N_KEY(N_KEY), .DB_CYCLES(DB)
  ) dut (
    .io_clk(io_clk),
    .reset (reset),
    .io    (io.slave)
  );

  always #5 io_clk = ~io_clk;

  // reference state: sync delay line, window of the last
  // DB synchronized samples since reset, accepted levels
  logic [NB-1:0] m_s1, m_s2, m_db;
  logic [NB-1:0] win[$];
  logic [3:0]    m_flag;
  logic [7:0]    m_cnt;

  function automatic logic [31:0] exp_p0();
    return 32'(m_db[N_SW-1:0]);
  endfunction

  function automatic logic [31:0] exp_p1();
    return {16'b0, m_cnt, m_flag, m_db[NB-1:N_SW]};
  endfunction

  task automatic model_edge();
    logic [NB-1:0]    nd;
    logic [N_KEY-1:0] rise;
    bit               ok;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      m_flag = '0; m_cnt = '0;
      win.delete();
    end else begin
      win.push_back(m_s2);
      if (win.size() > DB) void'(win.pop_front());
      nd = m_db;
      for (int i = 0; i < NB; i++) begin
        if (win.size() == DB) begin
          ok = 1'b1;
          foreach (win[k]) if (win[k][i] == m_db[i]) ok = 1'b0;
          if (ok) nd[i] = ~m_db[i];
        end
      end
      rise = nd[NB-1:N_SW] & ~m_db[NB-1:N_SW];
      if (io.ack_clr) m_flag = 4'(rise);
      else            m_flag = m_flag | 4'(rise);
      if (rise[0]) m_cnt = m_cnt + 8'd1;
      m_db = nd;
      m_s2 = m_s1;
      m_s1 = {~io.key_n, io.sw};
    end
  endtask

  task automatic step();
    @(posedge io_clk);
    model_edge();
    @(negedge io_clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    io.sw = '0; io.key_n = '1; io.ack_clr = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io.sw = 10'h3FF; io.key_n = 4'h0; io.ack_clr = 1'b1;
    step(); step();
    checks++;
    if (io.in_port0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_p0: got %h want 0", io.in_port0);
    end
    checks++;
    if (io.in_port1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_p1: got %h want 0", io.in_port1);
    end
    io.sw = '0; io.key_n = '1; io.ack_clr = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_clean_switch();
    logic [31:0] req;
    do_reset();
    io.sw = 10'h2A5;
    for (int e = 1; e <= 24; e++) begin
      step();
      req = (e >= DB + 2) ? 32'h2A5 : 32'h0;
      checks++;
      if (io.in_port0 !== req) begin
        errors++;
        $display("FAIL clean_sw e%0d: got %h want %h",
                 e, io.in_port0, req);
      end
      checks++;
      if (io.in_port0 !== exp_p0()) begin
        errors++;
        $display("FAIL clean_sw_model e%0d: got %h want %h",
                 e, io.in_port0, exp_p0());
      end
    end
  endtask

  task automatic test_bounce();
    int  rises = 0;
    logic prev;
    do_reset();
    prev = io.in_port1[1];
    for (int c = 0; c < 70; c++) begin
      io.key_n[1] = (c >= 40) ? 1'b0 : (((c / 3) % 2) != 0);
      step();
      if (io.in_port1[1] && !prev) rises++;
      prev = io.in_port1[1];
      checks++;
      if (io.in_port1 !== exp_p1()) begin
        errors++;
        $display("FAIL bounce_model c%0d: got %h want %h",
                 c, io.in_port1, exp_p1());
      end
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL bounce_rises: got %0d want 1", rises);
    end
    checks++;
    if (io.in_port1 !== 32'h22) begin
      errors++;
      $display("FAIL bounce_p1: got %h want 00000022", io.in_port1);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int c = 0; c < 50; c++) begin
      io.sw[0] = (c < DB - 1);
      step();
      checks++;
      if (io.in_port0 !== 32'h0) begin
        errors++;
        $display("FAIL glitch c%0d: got %h want 0", c, io.in_port0);
      end
      checks++;
      if (io.in_port0 !== exp_p0()) begin
        errors++;
        $display("FAIL glitch_model c%0d: got %h want %h",
                 c, io.in_port0, exp_p0());
      end
    end
  endtask

  task automatic test_flag_race();
    do_reset();
    io.key_n[3] = 1'b0;
    repeat (20) step();
    io.key_n[3] = 1'b1;
    repeat (20) step();
    checks++;
    if (io.in_port1[7:4] !== 4'b1000) begin
      errors++;
      $display("FAIL race_pre: got %b want 1000", io.in_port1[7:4]);
    end
    io.key_n[2] = 1'b0;
    for (int e = 1; e <= DB + 2; e++) begin
      io.ack_clr = (e == DB + 2);
      step();
      checks++;
      if (io.in_port1 !== exp_p1()) begin
        errors++;
        $display("FAIL race_model e%0d: got %h want %h",
                 e, io.in_port1, exp_p1());
      end
    end
    io.ack_clr = 1'b0;
    checks++;
    if (io.in_port1[7:0] !== 8'b0100_0100) begin
      errors++;
      $display("FAIL race_flags: got %b want 01000100",
               io.in_port1[7:0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int p = 0; p < 256; p++) begin
      io.key_n[0] = 1'b0;
      repeat (20) step();
      checks++;
      if (io.in_port1[15:8] !== 8'(p + 1)) begin
        errors++;
        $display("FAIL wrap_cnt p%0d: got %h want %h",
                 p, io.in_port1[15:8], 8'(p + 1));
      end
      io.key_n[0] = 1'b1;
      repeat (20) step();
      checks++;
      if (io.in_port1 !== exp_p1()) begin
        errors++;
        $display("FAIL wrap_model p%0d: got %h want %h",
                 p, io.in_port1, exp_p1());
      end
    end
    checks++;
    if (io.in_port1 !== 32'h10) begin
      errors++;
      $display("FAIL wrap_end: got %h want 00000010", io.in_port1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] req;
    do_reset();
    io.sw[3] = 1'b1;
    repeat (12) step();
    reset = 1'b1;
    step();
    checks++;
    if (io.in_port0 !== 32'h0 || io.in_port1 !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got %h/%h want 0/0",
               io.in_port0, io.in_port1);
    end
    reset = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      step();
      req = (e >= DB + 2) ? 32'h8 : 32'h0;
      checks++;
      if (io.in_port0 !== req) begin
        errors++;
        $display("FAIL mid_rel e%0d: got %h want %h",
                 e, io.in_port0, req);
      end
    end
  endtask

  task automatic test_random();
    int pct;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) pct = ($urandom_range(0, 2) == 0) ? 30 : 2;
      if ($urandom_range(0, 99) < pct)
        io.sw[$urandom_range(0, N_SW - 1)] ^= 1'b1;
      if ($urandom_range(0, 99) < pct)
        io.key_n[$urandom_range(0, N_KEY - 1)] ^= 1'b1;
      io.ack_clr = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 599) == 0);
      step();
      checks++;
      if (io.in_port0 !== exp_p0()) begin
        errors++;
        $display("FAIL rand_p0 c%0d: got %h want %h",
                 c, io.in_port0, exp_p0());
      end
      checks++;
      if (io.in_port1 !== exp_p1()) begin
        errors++;
        $display("FAIL rand_p1 c%0d: got %h want %h",
                 c, io.in_port1, exp_p1());
      end
    end
    reset = 1'b0;
    io.ack_clr = 1'b0;
  endtask

  initial begin
    io.sw = '0; io.key_n = '1; io.ack_clr = 1'b0;
    m_s1 = '0; m_s2 = '0; m_db = '0;
    m_flag = '0; m_cnt = '0;
    test_reset();
    test_clean_switch();
    test_bounce();
    test_glitch();
    test_flag_race();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
